pipeline_hazard_controller: RTL and testbench

- Sequences the in-order pipeline around the decoder.
- Generates PCWrite, IF_IDWrite, IF_IDFlush and the ID_EXBubble input consumed by the decoder.
- Resolves load-use hazards, branch/jump redirects and multi-cycle data-memory waits.
- Sits beside the ID stage; watches ID/EX/MEM pipeline registers; owns the memory-wait timeout and stall statistics.

---
 rtl/pipeline_hazard_controller.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing beside the ID stage: load-use bubbles, redirect flushes,
// data-memory freeze with a timeout fault, and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_MemReadEn,
    input  logic              ex_redirect,
    input  logic              mem_access,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              IF_IDWrite,
    output logic              IF_IDFlush,
    output logic              ID_EXBubble,
    output logic              pipe_hold,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
    logic             lu, mw;

    // x0 is hardwired zero, so a load targeting it can never create a dependency.
    assign lu = ex_MemReadEn && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    assign mw = mem_access && !mem_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; combinational blocks use blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        unique case (state)
            RUN: begin
                if (mw) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end else begin
                    wait_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                if (!mw) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
                    state_next = FAULT;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            FAULT:   state_next = FAULT;
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Reset is decoded directly so the pipeline is quiesced without waiting for a clock.
    always_comb begin
        PCWrite     = 1'b1;
        IF_IDWrite  = 1'b1;
        IF_IDFlush  = 1'b0;
        ID_EXBubble = 1'b0;
        pipe_hold   = 1'b0;
        if (!rst_n) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            IF_IDFlush  = 1'b1;
            ID_EXBubble = 1'b1;
        end else if (state == FAULT) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXBubble = 1'b1;
            pipe_hold   = 1'b1;
        end else if (mw) begin
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            pipe_hold  = 1'b1;
        end else if (ex_redirect) begin
            IF_IDFlush  = 1'b1;
            ID_EXBubble = 1'b1;
        end else if (lu) begin
            PCWrite     = 1'b0;
            IF_IDWrite  = 1'b0;
            ID_EXBubble = 1'b1;
        end
    end

    assign mem_timeout = (state == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!PCWrite && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: hazards, redirects, memory
// freeze, timeout fault, counter saturation and asynchronous reset.
module tb_pipeline_hazard_controller;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, ex_MemReadEn, ex_redirect, mem_access, mem_ready;
    logic       PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, pipe_hold, mem_timeout;
    logic [3:0] stall_cycles;
    logic [4:0] ctl;

    int checks = 0;
    int errors = 0;

    // {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, pipe_hold}
    localparam logic [4:0] CTL_NORMAL   = 5'b11000;
    localparam logic [4:0] CTL_LOADUSE  = 5'b00010;
    localparam logic [4:0] CTL_REDIRECT = 5'b11110;
    localparam logic [4:0] CTL_FREEZE   = 5'b00001;
    localparam logic [4:0] CTL_FAULT    = 5'b00011;
    localparam logic [4:0] CTL_RESET    = 5'b00110;

    pipeline_hazard_controller #(
        .TIMEOUT (4),
        .CNT_W   (8),
        .PERF_W  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_MemReadEn (ex_MemReadEn),
        .ex_redirect  (ex_redirect),
        .mem_access   (mem_access),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .IF_IDWrite   (IF_IDWrite),
        .IF_IDFlush   (IF_IDFlush),
        .ID_EXBubble  (ID_EXBubble),
        .pipe_hold    (pipe_hold),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    assign ctl = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXBubble, pipe_hold};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses_rs2,
                         input logic [4:0] rd, input logic mem_rd, input logic redir,
                         input logic acc, input logic rdy);
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs2  = uses_rs2;
        ex_rd        = rd;
        ex_MemReadEn = mem_rd;
        ex_redirect  = redir;
        mem_access   = acc;
        mem_ready    = rdy;
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_ctl", 32'(ctl), 32'(CTL_RESET));
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);

        #10 rst_n = 1'b1;
        next_cycle();

        drive(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        to_sample();
        check("normal_ctl", 32'(ctl), 32'(CTL_NORMAL));
        check("normal_stall", 32'(stall_cycles), 32'd0);
        next_cycle();

        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        to_sample();
        check("lu_rs1_ctl", 32'(ctl), 32'(CTL_LOADUSE));
        next_cycle();

        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        to_sample();
        check("lu_after_ctl", 32'(ctl), 32'(CTL_NORMAL));
        check("lu_after_stall", 32'(stall_cycles), 32'd1);
        next_cycle();

        drive(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        to_sample();
        check("rs2_unused_ctl", 32'(ctl), 32'(CTL_NORMAL));
        next_cycle();

        drive(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        to_sample();
        check("rs2_used_ctl", 32'(ctl), 32'(CTL_LOADUSE));
        next_cycle();

        drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        to_sample();
        check("x0_ctl", 32'(ctl), 32'(CTL_NORMAL));
        check("x0_stall", 32'(stall_cycles), 32'd2);
        next_cycle();

        drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        to_sample();
        check("redirect_lu_ctl", 32'(ctl), 32'(CTL_REDIRECT));
        next_cycle();

        // Memory wait with a redirect pending in the frozen EX stage.
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            to_sample();
            check($sformatf("memwait_ctl_%0d", i), 32'(ctl), 32'(CTL_FREEZE));
            next_cycle();
        end
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        to_sample();
        check("release_ctl", 32'(ctl), 32'(CTL_REDIRECT));
        check("release_stall", 32'(stall_cycles), 32'd5);
        next_cycle();

        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        to_sample();
        check("post_release_ctl", 32'(ctl), 32'(CTL_NORMAL));
        check("post_release_timeout", 32'(mem_timeout), 32'd0);
        next_cycle();

        // Timeout: one RUN cycle plus wait_cnt 1..4 in MEM_WAIT, then FAULT.
        for (int i = 0; i < 5; i++) begin
            drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            to_sample();
            check($sformatf("to_freeze_ctl_%0d", i), 32'(ctl), 32'(CTL_FREEZE));
            check($sformatf("to_freeze_flag_%0d", i), 32'(mem_timeout), 32'd0);
            next_cycle();
        end
        to_sample();
        check("fault_ctl", 32'(ctl), 32'(CTL_FAULT));
        check("fault_flag", 32'(mem_timeout), 32'd1);
        check("fault_stall", 32'(stall_cycles), 32'd10);
        next_cycle();

        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        to_sample();
        check("fault_sticky_flag", 32'(mem_timeout), 32'd1);
        check("fault_sticky_ctl", 32'(ctl), 32'(CTL_FAULT));
        check("fault_sticky_stall", 32'(stall_cycles), 32'd11);
        next_cycle();

        for (int i = 0; i < 20; i++) next_cycle();
        to_sample();
        check("sat_stall", 32'(stall_cycles), 32'd15);
        next_cycle();

        // Asynchronous reset in FAULT, well away from any clock edge.
        rst_n = 1'b0;
        #1;
        check("async_rst_flag", 32'(mem_timeout), 32'd0);
        check("async_rst_stall", 32'(stall_cycles), 32'd0);
        check("async_rst_ctl", 32'(ctl), 32'(CTL_RESET));
        #1 rst_n = 1'b1;
        next_cycle();

        drive(5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        to_sample();
        check("post_rst_lu_ctl", 32'(ctl), 32'(CTL_LOADUSE));
        check("post_rst_flag", 32'(mem_timeout), 32'd0);
        next_cycle();

        drive(5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        to_sample();
        check("post_rst_ctl", 32'(ctl), 32'(CTL_NORMAL));
        check("post_rst_stall", 32'(stall_cycles), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
